// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the hex-to-segment lookup.
// Bit order is {a,b,c,d,e,f,g} with segment a at bit 6, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  // 0xF is the keypad "empty" nibble, so it renders blank rather than 'F'.
  localparam logic [6:0] SEG_F     = SEG_BLANK;

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bundle: number/dp data in from the keypad side, scanned
// digit selects and segment lines out to the board.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 3
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   select;
  logic [6:0]              seg;
  logic                    dp;

  modport master (output value, dp_mask, input select, seg, dp);
  modport slave  (input value, dp_mask, output select, seg, dp);
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg7(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: rotating one-cold digit select with
// registered, mutually aligned select/seg/dp outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 1
) (
  input logic          clk,
  input logic          rst,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [IDX_W-1:0]      idx_q, idx_d, idx_cur;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  active_q;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic [NUM_DIGITS-1:0] select_d, select_q;
  logic                  dp_d, dp_q;
  logic [6:0]            seg_q;

  // The first edge out of reset only enters digit 0, so it gets a full dwell.
  always_comb begin
    idx_cur = (idx_q > IDX_LAST) ? '0 : idx_q;
    idx_d   = idx_cur;
    div_d   = div_q;
    if (!active_q) begin
      idx_d = '0;
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_cur == IDX_LAST) ? '0 : idx_cur + IDX_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_comb begin
    nibble   = '0;
    dp_d     = 1'b0;
    select_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble      = bus.value[4*i +: 4];
        dp_d        = bus.dp_mask[i];
        select_d[i] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      div_q    <= '0;
      active_q <= 1'b0;
      select_q <= '1;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      div_q    <= div_d;
      active_q <= 1'b1;
      select_q <= select_d;
      seg_q    <= seg_dec;
      dp_q     <= dp_d;
    end
  end

  assign bus.select = select_q;
  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: one driver with single-cycle dwell, one with 4-cycle dwell.
module tb_seg7_scan_driver;

  logic clk;
  logic rst1;
  logic rst4;
  int   checks;
  int   failures;

  seg7_scan_driver_if #(.NUM_DIGITS(3)) ifa ();
  seg7_scan_driver_if #(.NUM_DIGITS(3)) ifb ();

  seg7_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(1)) dut_a (
    .clk (clk),
    .rst (rst1),
    .bus (ifa)
  );

  seg7_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(4)) dut_b (
    .clk (clk),
    .rst (rst4),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h00};
  logic [2:0] sel_seq [3] = '{3'b101, 3'b011, 3'b110};
  logic [6:0] seg_seq [3] = '{7'h6D, 7'h30, 7'h79};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;
    checks   = 0;
    failures = 0;
    rst1 = 1'b1;
    rst4 = 1'b1;
    ifa.value   = 12'h123;
    ifa.dp_mask = 3'b000;
    ifb.value   = 12'h123;
    ifb.dp_mask = 3'b000;

    // reset held for three edges
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_select", 32'(ifa.select), 32'h7);
      chk("rst_seg", 32'(ifa.seg), 32'h00);
      chk("rst_dp", 32'(ifa.dp), 32'h0);
    end
    chk("rstb_select", 32'(ifb.select), 32'h7);

    rst1 = 1'b0;
    step();
    chk("first_select", 32'(ifa.select), 32'h6);
    chk("first_seg", 32'(ifa.seg), 32'h79);

    // scan order, two full rotations
    for (int k = 0; k < 6; k++) begin
      step();
      chk("scan_select", 32'(ifa.select), 32'(sel_seq[k % 3]));
      chk("scan_seg", 32'(ifa.seg), 32'(seg_seq[k % 3]));
    end

    // full decode sweep on digit 0
    for (int n = 0; n < 16; n++) begin
      ifa.value = 12'(n);
      found = 1'b0;
      for (int t = 0; t < 3 && !found; t++) begin
        step();
        if (ifa.select == 3'b110) found = 1'b1;
      end
      chk("sweep_found", 32'(found), 32'h1);
      chk("sweep_select", 32'(ifa.select), 32'h6);
      chk($sformatf("sweep_seg_%0h", n), 32'(ifa.seg), 32'(dec_tab[n]));
    end

    // decimal point on blank digits
    ifa.value   = 12'hFFF;
    ifa.dp_mask = 3'b010;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("dp_select", 32'(ifa.select), 32'(sel_seq[k % 3]));
      chk("dp_seg", 32'(ifa.seg), 32'h00);
      chk("dp_dp", 32'(ifa.dp), (k % 3 == 0) ? 32'h1 : 32'h0);
    end

    // 4-cycle dwell
    rst4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("dwell_select", 32'(ifb.select), (k < 4) ? 32'h6 : (k < 8) ? 32'h5 : 32'h3);
      chk("dwell_seg", 32'(ifb.seg), (k < 4) ? 32'h79 : (k < 8) ? 32'h6D : 32'h30);
    end

    // mid-dwell reset on digit 2
    rst4 = 1'b1;
    ifb.value = 12'h000;
    step();
    chk("midrst_select", 32'(ifb.select), 32'h7);
    chk("midrst_seg", 32'(ifb.seg), 32'h00);
    rst4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("restart_select", 32'(ifb.select), (k < 4) ? 32'h6 : 32'h5);
      chk("restart_seg", 32'(ifb.seg), 32'h7E);
    end

    // live update while digit 1 dwells
    ifb.value = 12'h0E0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("live_select", 32'(ifb.select), 32'h5);
      chk("live_seg", 32'(ifb.seg), 32'h4F);
    end
    step();
    chk("live_next_select", 32'(ifb.select), 32'h3);
    chk("live_next_seg", 32'(ifb.seg), 32'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
